panel_input: RTL and testbench

PANEL_INPUT -- requirements
Module: panel_input

---
 rtl/panel_input.sv | 158 +++++++++++++++
 tb/tb_panel_input.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/panel_input.sv
// Washer front panel: synchronise and debounce four keys, then drive the OFF/SET/RUN/PAUSE panel FSM.
// Build with AUTO_OFF_EN defined to add an idle timer that powers the panel off from SET.

module panel_input #(
    parameter int unsigned DEB_CYC  = 20000,
    parameter int unsigned IDLE_CYC = 30000000
) (
    input  logic       clk,
    input  logic       uRST_,
    input  logic [3:0] uKey,
    input  logic       uDone,
    output logic [1:0] yState,
    output logic [5:0] yTot,
    output logic [5:0] yWat,
    output logic       yStart,
    output logic       yRun
);

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_SET   = 2'd1,
        ST_RUN   = 2'd2,
        ST_PAUSE = 2'd3
    } state_t;

    localparam logic [15:0] DEB_LAST = 16'(DEB_CYC - 1);

    logic [3:0]  sync1_q, sync2_q, deb_q, debPrev_q, press_q;
    logic [15:0] cnt_q [4];

    state_t      state_q, state_d;
    logic [1:0]  prog_q, prog_d;
    logic [2:0]  wat_q, wat_d;
    logic        start_q, start_d;
    logic        run_q;

    // A key's debounced level flips only after DEB_CYC consecutive disagreeing cycles.
    always_ff @(posedge clk or negedge uRST_) begin
        if (!uRST_) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            deb_q     <= '0;
            debPrev_q <= '0;
            press_q   <= '0;
            for (int k = 0; k < 4; k++) cnt_q[k] <= '0;
        end else begin
            sync1_q   <= uKey;
            sync2_q   <= sync1_q;
            debPrev_q <= deb_q;
            press_q   <= deb_q & ~debPrev_q;
            for (int k = 0; k < 4; k++) begin
                if (sync2_q[k] == deb_q[k]) begin
                    cnt_q[k] <= '0;
                end else if (cnt_q[k] == DEB_LAST) begin
                    cnt_q[k] <= '0;
                    deb_q[k] <= sync2_q[k];
                end else begin
                    cnt_q[k] <= cnt_q[k] + 16'd1;
                end
            end
        end
    end

`ifdef AUTO_OFF_EN
    localparam int unsigned IDLE_W = (IDLE_CYC > 2) ? $clog2(IDLE_CYC) : 1;
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_CYC - 1);

    logic [IDLE_W-1:0] idle_q, idle_d;

    always_ff @(posedge clk or negedge uRST_) begin
        if (!uRST_) idle_q <= '0;
        else        idle_q <= idle_d;
    end
`endif

    // Strict priority: the highest pending event wins, everything below it is dropped.
    always_comb begin
        state_d = state_q;
        prog_d  = prog_q;
        wat_d   = wat_q;
        start_d = 1'b0;
        if (press_q[0]) begin
            if (state_q == ST_OFF) begin
                state_d = ST_SET;
                prog_d  = 2'd0;
                wat_d   = 3'd3;
            end else begin
                state_d = ST_OFF;
            end
        end else if (uDone) begin
            if (state_q == ST_RUN) state_d = ST_SET;
        end else if (press_q[1]) begin
            case (state_q)
                ST_SET: begin
                    state_d = ST_RUN;
                    start_d = 1'b1;
                end
                ST_RUN:   state_d = ST_PAUSE;
                ST_PAUSE: state_d = ST_RUN;
                default:  state_d = state_q;
            endcase
        end else if (press_q[2]) begin
            if (state_q == ST_SET) prog_d = prog_q + 2'd1;
        end else if (press_q[3]) begin
            if (state_q == ST_SET) wat_d = (wat_q == 3'd5) ? 3'd1 : wat_q + 3'd1;
        end
`ifdef AUTO_OFF_EN
        idle_d = '0;
        if (state_q == ST_SET && state_d == ST_SET && prog_d == prog_q && wat_d == wat_q) begin
            if (idle_q == IDLE_LAST) state_d = ST_OFF;
            else                     idle_d  = idle_q + 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or negedge uRST_) begin
        if (!uRST_) begin
            state_q <= ST_OFF;
            prog_q  <= 2'd0;
            wat_q   <= 3'd3;
            start_q <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            prog_q  <= prog_d;
            wat_q   <= wat_d;
            start_q <= start_d;
            run_q   <= (state_d == ST_RUN);
        end
    end

    // 55 is the blank display code shown while the panel is off.
    always_comb begin
        yTot = 6'd55;
        yWat = 6'd55;
        if (state_q != ST_OFF) begin
            case (prog_q)
                2'd0:    yTot = 6'd35;
                2'd1:    yTot = 6'd22;
                2'd2:    yTot = 6'd15;
                default: yTot = 6'd9;
            endcase
            case (wat_q)
                3'd1:    yWat = 6'd10;
                3'd2:    yWat = 6'd20;
                3'd3:    yWat = 6'd30;
                3'd4:    yWat = 6'd40;
                3'd5:    yWat = 6'd50;
                default: yWat = 6'd55;
            endcase
        end
    end

    assign yState = state_q;
    assign yStart = start_q;
    assign yRun   = run_q;

endmodule

// File: tb/tb_panel_input.sv
// Bench for panel_input: directed panel scenarios plus random key traffic, all checked every cycle
// against a behavioural model of the key pipeline and panel rules.

module tb_panel_input;

    localparam int DEB  = 4;
    localparam int IDLE = 50;

    logic       clk = 1'b0;
    logic       uRST_ = 1'b1;
    logic [3:0] uKey = 4'b0000;
    logic       uDone = 1'b0;
    logic [1:0] yState;
    logic [5:0] yTot, yWat;
    logic       yStart, yRun;

    always #5 clk = ~clk;

    panel_input #(.DEB_CYC(DEB), .IDLE_CYC(IDLE)) dut (
        .clk    (clk),
        .uRST_  (uRST_),
        .uKey   (uKey),
        .uDone  (uDone),
        .yState (yState),
        .yTot   (yTot),
        .yWat   (yWat),
        .yStart (yStart),
        .yRun   (yRun)
    );

    int nChecks = 0;
    int nFails  = 0;
    bit cmpEn   = 1'b0;

    // Model state: raw-key history, consecutive-disagreement counts, pending press events, panel settings.
    bit [3:0] mH1, mH2, mDeb, stage1, stage2;
    int       mCnt [4];
    int       mState, mProg, mLvl, mStart, mIdle;
    int       totTab [4] = '{35, 22, 15, 9};

    function automatic int expTot();
        return (mState == 0) ? 55 : totTab[mProg];
    endfunction

    function automatic int expWat();
        return (mState == 0) ? 55 : 10 * mLvl;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        nChecks++;
        if (actual != expected) begin
            nFails++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        mH1 = '0; mH2 = '0; mDeb = '0; stage1 = '0; stage2 = '0;
        for (int k = 0; k < 4; k++) mCnt[k] = 0;
        mState = 0; mProg = 0; mLvl = 3; mStart = 0; mIdle = 0;
    endtask

    task automatic modelStep();
        bit [3:0] ev;
        bit [3:0] rose;
        bit       s;
        int       prevState, prevProg, prevLvl;
        ev     = stage2;
        stage2 = stage1;
        rose   = '0;
        for (int k = 0; k < 4; k++) begin
            s      = mH2[k];
            mH2[k] = mH1[k];
            mH1[k] = uKey[k];
            if (s != mDeb[k]) begin
                mCnt[k]++;
                if (mCnt[k] == DEB) begin
                    mDeb[k] = s;
                    mCnt[k] = 0;
                    rose[k] = s;
                end
            end else begin
                mCnt[k] = 0;
            end
        end
        stage1 = rose;

        prevState = mState; prevProg = mProg; prevLvl = mLvl;
        mStart = 0;
        if (ev[0]) begin
            if (mState == 0) begin mState = 1; mProg = 0; mLvl = 3; end
            else mState = 0;
        end else if (uDone) begin
            if (mState == 2) mState = 1;
        end else if (ev[1]) begin
            if (mState == 1) begin mState = 2; mStart = 1; end
            else if (mState == 2) mState = 3;
            else if (mState == 3) mState = 2;
        end else if (ev[2]) begin
            if (mState == 1) mProg = (mProg + 1) % 4;
        end else if (ev[3]) begin
            if (mState == 1) mLvl = (mLvl % 5) + 1;
        end
`ifdef AUTO_OFF_EN
        if (prevState == 1 && mState == 1 && mProg == prevProg && mLvl == prevLvl) begin
            if (mIdle == IDLE - 1) begin mState = 0; mIdle = 0; end
            else mIdle++;
        end else begin
            mIdle = 0;
        end
`else
        mIdle = (prevProg == mProg && prevLvl == mLvl) ? mIdle : 0;
`endif
    endtask

    initial forever begin
        @(posedge clk or negedge uRST_);
        if (!uRST_) modelReset();
        else        modelStep();
    end

    // Compare process: every output against the model, every cycle once enabled.
    always @(negedge clk) begin
        if (cmpEn) begin
            checkOutput("cmp yState", int'(yState), mState);
            checkOutput("cmp yTot",   int'(yTot),   expTot());
            checkOutput("cmp yWat",   int'(yWat),   expWat());
            checkOutput("cmp yStart", int'(yStart), mStart);
            checkOutput("cmp yRun",   int'(yRun),   (mState == 2) ? 1 : 0);
        end
    end

    task automatic pressKey(input int k);
        uKey[k] = 1'b1;
        repeat (DEB + 4) @(negedge clk);
    endtask

    task automatic releaseKey(input int k);
        uKey[k] = 1'b0;
        repeat (DEB + 6) @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [3:0] key, input bit done, input int hold);
        uKey  = key;
        uDone = done;
        @(negedge clk);
        uDone = 1'b0;
        repeat (hold - 1) @(negedge clk);
    endtask

    int progSeq [5] = '{22, 15, 9, 35, 22};
    int watSeq  [6] = '{40, 50, 10, 20, 30, 40};

    initial begin
        modelReset();
        #1 uRST_ = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst yState", int'(yState), 0);
        checkOutput("rst yTot",   int'(yTot),   55);
        checkOutput("rst yWat",   int'(yWat),   55);
        checkOutput("rst yStart", int'(yStart), 0);
        checkOutput("rst yRun",   int'(yRun),   0);
        uRST_ = 1'b1;
        cmpEn = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] power on latency");
        uKey[0] = 1'b1;
        repeat (DEB + 3) @(negedge clk);
        checkOutput("pwr edge7 yState", int'(yState), 0);
        @(negedge clk);
        checkOutput("pwr edge8 yState", int'(yState), 1);
        checkOutput("pwr yTot", int'(yTot), 35);
        checkOutput("pwr yWat", int'(yWat), 30);
        repeat (2) @(negedge clk);
        releaseKey(0);

        $display("[TB] glitch rejection");
        uKey[0] = 1'b1;
        repeat (DEB - 1) @(negedge clk);
        uKey[0] = 1'b0;
        repeat (12) @(negedge clk);
        checkOutput("glitch yState", int'(yState), 1);
        checkOutput("glitch yTot",   int'(yTot),   35);
        checkOutput("glitch yWat",   int'(yWat),   30);

        $display("[TB] program and water cycling");
        for (int i = 0; i < 5; i++) begin
            pressKey(2);
            checkOutput("prog yTot", int'(yTot), progSeq[i]);
            releaseKey(2);
        end
        for (int i = 0; i < 6; i++) begin
            pressKey(3);
            checkOutput("wat yWat", int'(yWat), watSeq[i]);
            releaseKey(3);
        end

        $display("[TB] start pause resume done");
        pressKey(1);
        checkOutput("start yStart", int'(yStart), 1);
        checkOutput("start yRun",   int'(yRun),   1);
        checkOutput("start yState", int'(yState), 2);
        @(negedge clk);
        checkOutput("start pulse end", int'(yStart), 0);
        releaseKey(1);
        pressKey(1);
        checkOutput("pause yState", int'(yState), 3);
        checkOutput("pause yRun",   int'(yRun),   0);
        releaseKey(1);
        pressKey(1);
        checkOutput("resume yState", int'(yState), 2);
        checkOutput("resume yStart", int'(yStart), 0);
        releaseKey(1);
        uDone = 1'b1;
        @(negedge clk);
        uDone = 1'b0;
        checkOutput("done yState", int'(yState), 1);
        checkOutput("done yTot",   int'(yTot),   22);
        checkOutput("done yWat",   int'(yWat),   40);

        $display("[TB] priority");
        uKey = 4'b0101;
        repeat (DEB + 4) @(negedge clk);
        checkOutput("pwr+prog yState", int'(yState), 0);
        checkOutput("pwr+prog yTot",   int'(yTot),   55);
        uKey = 4'b0000;
        repeat (DEB + 6) @(negedge clk);
        pressKey(0);
        checkOutput("repower yTot", int'(yTot), 35);
        releaseKey(0);
        pressKey(1);
        releaseKey(1);
        uKey[1] = 1'b1;
        repeat (DEB + 3) @(negedge clk);
        uDone = 1'b1;
        @(negedge clk);
        uDone = 1'b0;
        checkOutput("done+start yState", int'(yState), 1);
        releaseKey(1);

`ifdef AUTO_OFF_EN
        $display("[TB] idle auto-off");
        repeat (IDLE + 5) @(negedge clk);
        checkOutput("autooff yState", int'(yState), 0);
        pressKey(0);
        releaseKey(0);
`else
        $display("[TB] SET persists");
        repeat (200) @(negedge clk);
        checkOutput("persist yState", int'(yState), 1);
`endif

        $display("[TB] reset mid-RUN and key held across release");
        pressKey(1);
        checkOutput("prerst yState", int'(yState), 2);
        @(posedge clk);
        #2 uRST_ = 1'b0;
        uKey = 4'b0001;
        #1;
        checkOutput("async yState", int'(yState), 0);
        checkOutput("async yTot",   int'(yTot),   55);
        checkOutput("async yWat",   int'(yWat),   55);
        checkOutput("async yStart", int'(yStart), 0);
        checkOutput("async yRun",   int'(yRun),   0);
        repeat (3) @(negedge clk);
        uRST_ = 1'b1;
        repeat (DEB + 3) @(negedge clk);
        checkOutput("held edge7 yState", int'(yState), 0);
        @(negedge clk);
        checkOutput("held edge8 yState", int'(yState), 1);
        checkOutput("held yTot",   int'(yTot),   35);
        checkOutput("held yWat",   int'(yWat),   30);
        releaseKey(0);

        $display("[TB] random traffic");
        for (int i = 0; i < 300; i++) begin
            int r;
            logic [3:0] key;
            bit done;
            r    = $urandom_range(0, 9);
            key  = 4'b0000;
            if (r < 4)       key = 4'(1 << $urandom_range(0, 3));
            else if (r == 4) key = 4'($urandom_range(0, 15));
            done = (mState == 2) && ($urandom_range(0, 5) == 0);
            applyStimulus(key, done, $urandom_range(1, 9));
        end
        applyStimulus(4'b0000, 1'b0, DEB + 8);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
